// File: rtl/ip4_rtl_spa_arb.sv
// ip4_rtl_spa_arb: round-robin issue arbiter feeding a single registered
// issue slot of the SP array. Long ops lock out further grants for
// LNG_LAT issue cycles.
// Optional feature macro: IP4_SPA_ARB_PRIO_EN adds req_prio, which restricts
// the round-robin scan to prioritised requesters whenever any of them is valid.
module ip4_rtl_spa_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned OPW     = 8,
  parameter int unsigned LNG_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_vld,
  input  logic [NREQ*OPW-1:0]      req_op,
  input  logic [NREQ-1:0]          req_lng,
`ifdef IP4_SPA_ARB_PRIO_EN
  input  logic [NREQ-1:0]          req_prio,
`endif
  output logic [NREQ-1:0]          req_rdy,
  output logic                     iss_vld,
  input  logic                     iss_rdy,
  output logic [OPW-1:0]           iss_op,
  output logic [$clog2(NREQ)-1:0]  iss_id,
  output logic                     busy
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CNTW = 4;
  localparam bit          LOCK_EN = (LNG_LAT > 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]      r_state;
  logic [CNTW-1:0] r_cnt;
  logic            r_iss_vld;
  logic [OPW-1:0]  r_iss_op;
  logic [IDW-1:0]  r_iss_id;
  logic [IDW-1:0]  r_ptr;

  logic [0:0]      w_state_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_iss_vld_nxt;
  logic [OPW-1:0]  w_iss_op_nxt;
  logic [IDW-1:0]  w_iss_id_nxt;
  logic [IDW-1:0]  w_ptr_nxt;

  logic [NREQ-1:0] w_cand;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_win;
  logic            w_found;
  logic            w_slot_free;
  logic            w_grant;
  logic            w_win_lng;
  logic [OPW-1:0]  w_win_op;

  // Candidate set and first-set scan starting at the rotating pointer
  always_comb begin
    w_cand  = req_vld;
`ifdef IP4_SPA_ARB_PRIO_EN
    if (|(req_vld & req_prio)) w_cand = req_vld & req_prio;
`endif
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Grant qualification: free slot, unlocked, not flushing or resetting
  always_comb begin
    w_slot_free = !r_iss_vld || iss_rdy;
    w_grant     = w_slot_free && (r_state == S_IDLE) && !flush && !rst && w_found;
    w_win_lng   = req_lng[w_win];
    w_win_op    = req_op[32'(w_win)*OPW +: OPW];
    req_rdy     = w_grant ? (NREQ'(1) << w_win) : '0;
  end

  // Next-state: FSM, lock counter, issue slot and pointer
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_iss_vld_nxt = r_iss_vld;
    w_iss_op_nxt  = r_iss_op;
    w_iss_id_nxt  = r_iss_id;
    w_ptr_nxt     = r_ptr;

    if (flush) begin
      w_iss_vld_nxt = 1'b0;
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
    end else begin
      if (w_grant) begin
        w_iss_vld_nxt = 1'b1;
        w_iss_op_nxt  = w_win_op;
        w_iss_id_nxt  = w_win;
        w_ptr_nxt     = IDW'((32'(w_win) + 1) % NREQ);
        if (LOCK_EN && w_win_lng) begin
          w_state_nxt = S_LOCK;
          w_cnt_nxt   = CNTW'(LNG_LAT - 1);
        end
      end else if (iss_rdy) begin
        w_iss_vld_nxt = 1'b0;
      end

      // Lock countdown runs regardless of downstream back-pressure
      if (r_state == S_LOCK) begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNTW'(1);
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_iss_vld <= 1'b0;
      r_iss_op  <= '0;
      r_iss_id  <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_iss_vld <= w_iss_vld_nxt;
      r_iss_op  <= w_iss_op_nxt;
      r_iss_id  <= w_iss_id_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign iss_vld = r_iss_vld;
  assign iss_op  = r_iss_op;
  assign iss_id  = r_iss_id;
  assign busy    = r_iss_vld || (r_state == S_LOCK);

endmodule

// File: tb/tb_ip4_rtl_spa_arb.sv
// Self-checking bench for ip4_rtl_spa_arb: directed scenarios plus random
// traffic compared every cycle against a cycle-level behavioural model.
module tb_ip4_rtl_spa_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned OPW  = 8;
  localparam int unsigned LAT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, iss_rdy;
  logic [3:0]  req_vld, req_lng;
  logic [31:0] req_op;
`ifdef IP4_SPA_ARB_PRIO_EN
  logic [3:0]  req_prio;
`endif
  logic [3:0]  req_rdy, rdy1;
  logic        iss_vld, vld1, busy, busy1;
  logic [7:0]  iss_op, op1;
  logic [1:0]  iss_id, id1;

  ip4_rtl_spa_arb #(.NREQ(NREQ), .OPW(OPW), .LNG_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_vld(req_vld), .req_op(req_op),
    .req_lng(req_lng),
`ifdef IP4_SPA_ARB_PRIO_EN
    .req_prio(req_prio),
`endif
    .req_rdy(req_rdy), .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_op(iss_op),
    .iss_id(iss_id), .busy(busy));

  // Second instance with LNG_LAT=1: long ops must never lock
  ip4_rtl_spa_arb #(.NREQ(NREQ), .OPW(OPW), .LNG_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .req_vld(req_vld), .req_op(req_op),
    .req_lng(req_lng),
`ifdef IP4_SPA_ARB_PRIO_EN
    .req_prio(req_prio),
`endif
    .req_rdy(rdy1), .iss_vld(vld1), .iss_rdy(iss_rdy), .iss_op(op1),
    .iss_id(id1), .busy(busy1));

  // Behavioural model: issue slot contents plus a count of grant-blocked cycles
  bit         m_vld;
  logic [7:0] m_op;
  int         m_id, m_ptr, m_block;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_op = '0; m_id = 0; m_ptr = 0; m_block = 0;
  endtask

  // Compare DUT against the model for the current cycle, then advance one edge
  task automatic step();
    logic [3:0] c;
    logic [3:0] er;
    int w;
    bit g;
    #2;
    c = req_vld;
`ifdef IP4_SPA_ARB_PRIO_EN
    if ((req_vld & req_prio) != 4'b0) c = req_vld & req_prio;
`endif
    w = -1;
    for (int k = 0; k < int'(NREQ); k++)
      if (w < 0 && c[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    g  = (!m_vld || iss_rdy) && (m_block == 0) && !flush && !rst && (w >= 0);
    er = g ? (4'b0001 << w) : 4'b0000;
    chk("req_rdy", 32'(req_rdy), 32'(er));
    chk("iss_vld", 32'(iss_vld), 32'(m_vld));
    chk("busy", 32'(busy), 32'(m_vld || m_block > 0));
    if (m_vld) begin
      chk("iss_op", 32'(iss_op), 32'(m_op));
      chk("iss_id", 32'(iss_id), 32'(m_id));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (flush) begin
      m_vld = 1'b0; m_block = 0;
    end else if (g) begin
      m_vld = 1'b1;
      m_op  = req_op[w*OPW +: OPW];
      m_id  = w;
      m_ptr = (w + 1) % NREQ;
      if (req_lng[w] && LAT > 1) m_block = LAT - 1;
    end else begin
      if (iss_rdy) m_vld = 1'b0;
      if (m_block > 0) m_block--;
    end
    #1;
  endtask

  task automatic drain(input int n);
    req_vld = '0; req_lng = '0; iss_rdy = 1'b1; flush = 1'b0; rst = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iss_rdy = 1'b1;
    req_vld = 4'b1111; req_lng = '0;
    req_op = {8'h44, 8'hA7, 8'h5B, 8'h3C};
`ifdef IP4_SPA_ARB_PRIO_EN
    req_prio = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    // Reset state and no grant while rst is high
    chk("rst_rdy", 32'(req_rdy), 32'h0);
    chk("rst_vld", 32'(iss_vld), 32'h0);
    chk("rst_op", 32'(iss_op), 32'h0);
    chk("rst_id", 32'(iss_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step();

    // Back-to-back short issue: ids 0,1,2,3,0 with iss_vld continuously high
    rst = 1'b0; req_vld = 4'b1111; req_lng = '0; iss_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_id", 32'(iss_id), 32'(k % 4));
      chk("rr_vld", 32'(iss_vld), 32'h1);
    end
    drain(2);

    // Long op from requester 2: next grant exactly LAT cycles later
    req_vld = 4'b0100; req_lng = 4'b0100; iss_rdy = 1'b1;
    #1;
    chk("lng_grant", 32'(req_rdy), 32'h4);
    chk("lat1_grant", 32'(rdy1), 32'h4);
    step();
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("lng_lock_rdy", 32'(req_rdy), 32'h0);
      chk("lng_lock_busy", 32'(busy), 32'h1);
      chk("lat1_nolock", 32'(rdy1), 32'h4);
      step();
    end
    #1;
    chk("lng_regrant", 32'(req_rdy), 32'h4);
    step();
    drain(5);

    // Back-pressure hold of opcode 3C, then grant on iss_rdy rise
    req_vld = 4'b0001; req_lng = '0; iss_rdy = 1'b1;
    step();
    req_vld = 4'b0011; iss_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_op", 32'(iss_op), 32'h3C);
      chk("hold_rdy", 32'(req_rdy), 32'h0);
      step();
    end
    iss_rdy = 1'b1;
    #1;
    chk("hold_release", 32'(req_rdy), 32'h2);
    step();
    drain(2);

    // Flush during lock with a pending slot; grant resumes from retained ptr
    req_vld = 4'b0100; req_lng = 4'b0100; iss_rdy = 1'b0;
    step();
    req_vld = '0; req_lng = '0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; req_vld = 4'b1111;
    #1;
    chk("flush_vld", 32'(iss_vld), 32'h0);
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_ptr", 32'(req_rdy), 32'h8);
    step();
    drain(2);

    // Reset coinciding with a would-be grant to requester 1
    req_vld = 4'b0001;
    step();
    drain(1);
    req_vld = 4'b0010; rst = 1'b1;
    #1;
    chk("rstg_rdy", 32'(req_rdy), 32'h0);
    step();
    rst = 1'b0; req_vld = 4'b1111;
    #1;
    chk("rstg_vld", 32'(iss_vld), 32'h0);
    chk("rstg_ptr", 32'(req_rdy), 32'h1);
    step();
    drain(2);

`ifdef IP4_SPA_ARB_PRIO_EN
    // Priority subset always wins while held
    rst = 1'b1;
    step();
    rst = 1'b0; req_vld = 4'b1111; req_prio = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("prio_grant", 32'(req_rdy), 32'h4);
      step();
    end
    req_prio = '0;
    drain(2);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      req_vld = 4'($urandom);
      req_lng = 4'($urandom) & 4'($urandom);
      req_op  = $urandom;
      iss_rdy = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 99) < 3);
      rst     = ($urandom_range(0, 199) == 0);
`ifdef IP4_SPA_ARB_PRIO_EN
      req_prio = 4'($urandom) & 4'($urandom);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ip4_rtl_spa_arb.md
IP4_RTL_SPA_ARB -- requirements
Module: ip4_rtl_spa_arb

Interface
REQ-001 Parameter NREQ, default 4: number of issue requesters (thread groups) sharing the SP array; legal 2..8.
REQ-002 Parameter OPW, default 8: opcode width, matching opcode_e.
REQ-003 Parameter LNG_LAT, default 4: issue cycles occupied by a long (fp/long) op; legal 1..15.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port flush  input  1: synchronous pipeline clear.
REQ-007 Port req_vld  input  NREQ: per-requester issue request.
REQ-008 Port req_op  input  NREQ*OPW: per-requester opcode; slice i belongs to requester i.
REQ-009 Port req_lng  input  NREQ: per-requester long-op flag.
REQ-010 Port req_rdy  output  NREQ: one-hot grant; the request is consumed in the cycle req_vld[i] & req_rdy[i].
REQ-011 Port iss_vld  output  1: registered issue slot valid toward the SP array.
REQ-012 Port iss_rdy  input  1: SP array accepts the issue slot.
REQ-013 Port iss_op  output  OPW: registered issued opcode.
REQ-014 Port iss_id  output  $clog2(NREQ): registered index of the granted requester.
REQ-015 Port busy  output  1: iss_vld high or state LOCK.

Function
REQ-016 slot_free = !iss_vld | iss_rdy; a grant occurs only when slot_free, state IDLE, flush low, rst low and at least one req_vld is set.
REQ-017 Winner is the first set req_vld scanning from ptr upward, wrapping NREQ-1 to 0; req_rdy is combinational and is zero when no grant occurs.
REQ-018 On grant: iss_vld, iss_op and iss_id load on the next edge, giving 1-cycle latency from req_vld&req_rdy to iss_vld; ptr loads (winner+1) mod NREQ.
REQ-019 While iss_vld & !iss_rdy: iss_op and iss_id hold stable and no grant occurs.
REQ-020 When iss_vld & iss_rdy and no new grant occurs, iss_vld clears on the next edge; a simultaneous accept and grant keeps iss_vld high, so back-to-back issue proceeds at 1 per cycle.
REQ-021 FSM states are IDLE and LOCK; a grant with req_lng set and LNG_LAT>1 moves the FSM to LOCK with cnt = LNG_LAT-1.
REQ-022 In LOCK: no grants; cnt decrements each cycle; at cnt==1 the FSM returns to IDLE on that edge, so the next grant is exactly LNG_LAT cycles after the long grant, provided iss_rdy is high.
REQ-023 LOCK counting is independent of iss_rdy; the slot-hold rule of REQ-019 still applies after the FSM leaves LOCK.
REQ-024 With LNG_LAT==1, long ops behave as short ops and LOCK is never entered.
REQ-025 flush takes priority over all else: next edge iss_vld=0, FSM=IDLE, cnt=0; no grant in the flush cycle; ptr is retained.
REQ-026 A requester that lowers req_vld without a grant is simply skipped and is not recorded.

Reset
REQ-027 With rst high at an edge: iss_vld=0, iss_op=0, iss_id=0, ptr=0, cnt=0, FSM=IDLE; busy=0 from the next cycle.
REQ-028 req_rdy is all-zero in any cycle where rst is high; reset mid-LOCK or mid-hold discards the pending slot.

Configuration
REQ-029 Macro IP4_SPA_ARB_PRIO_EN defined: adds input port req_prio (NREQ bits); if any req_vld&req_prio bit is set, the round-robin scan of REQ-017 considers only those requesters; ptr updates as in REQ-018.
REQ-030 Macro IP4_SPA_ARB_PRIO_EN undefined: port req_prio is absent and arbitration is pure round-robin.

Verification
REQ-031 Reset, then req_vld=4'b1111 with all short ops and iss_rdy=1 -> iss_id sequence 0,1,2,3,0 on consecutive cycles, iss_vld continuously high.
REQ-032 Only req 2 valid with req_lng=1, LNG_LAT=4, grant at cycle t -> next req_rdy[2] at t+4; busy high t+1..t+3.
REQ-033 iss_vld=1, iss_op=8'h3C, iss_rdy=0 for 5 cycles with req_vld=4'b0011 -> iss_op stays 8'h3C, req_rdy=0 throughout; first grant occurs in the cycle iss_rdy rises.
REQ-034 flush asserted during LOCK (cnt=2) with iss_vld=1 -> next cycle iss_vld=0, busy=0; grant resumes the following cycle from the retained ptr.
REQ-035 rst asserted in the cycle of a grant to requester 1 -> req_rdy=0, iss_vld=0 afterward, ptr=0, so the first post-reset grant with all valid goes to id 0.
REQ-036 With IP4_SPA_ARB_PRIO_EN defined, req_vld=4'b1111, req_prio=4'b0100, ptr=0 -> grant id 2 each cycle while prio is held.
